alu_issue_queue: RTL and testbench
==================================

// Module: alu_issue_queue
// PURPOSE
//  Front-end issue stage for alu_gate. Queues ALU requests {ctrl, op1, op2} arriving on a valid/ready
//  handshake and drives the FIFO head onto the combinational ALU inputs. Captures the ALU's 8-bit result
//  into a registered, back-pressurable output with an error flag and a 4-bit sequence tag.
//  Decouples bursty request sources from the result consumer at one result per clock.
// PARAMETERS
//  DEPTH  4  request FIFO entries; power of two, >= 2
//  AW     2  pointer width, = log2(DEPTH)
// PORTS
//  i_clk       in   1   clock, rising edge
//  i_rst       in   1   reset, asynchronous, active-high
//  i_vld       in   1   request valid
//  o_rdy       out  1   request ready (FIFO not full)
//  i_ctrl      in   3   opcode: 0 add, 1 sub, 2 mult, 3 nand, 4 nor; 5..7 illegal
//  i_op1       in   4   operand 1
//  i_op2       in   4   operand 2
//  o_alu_ctrl  out  3   to alu_gate i_ctrl (FIFO head)
//  o_alu_op1   out  4   to alu_gate i_op1 (FIFO head)
//  o_alu_op2   out  4   to alu_gate i_op2 (FIFO head)
//  i_alu_dat   in   8   from alu_gate o_dat, combinational in o_alu_*
//  o_vld       out  1   result valid
//  i_rdy       in   1   result ready
//  o_dat       out  8   result
//  o_err       out  1   result came from an illegal opcode
//  o_seq       out  4   result sequence tag
//  o_count     out  AW+1  FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (async, immediate): wr/rd pointers = 0, count = 0, seq counter = 0, o_vld = 0, o_dat = 8'h00,
//   o_err = 0, o_seq = 0. Queued requests are discarded. o_rdy = 1 while i_rst is high and after release.
//  push = i_vld & o_rdy. o_rdy = (count != DEPTH) and does not depend on i_rdy or pop.
//   A full FIFO refuses a push even in a cycle that pops.
//  o_alu_* = FIFO head when count != 0; otherwise ctrl 3'b000, ops 4'h0.
//  pop = (count != 0) & (~o_vld | i_rdy). On pop, at the clock edge:
//   o_vld <= 1; o_seq <= seq counter; seq counter increments and wraps 15 -> 0.
//   If head ctrl <= 4: o_dat <= i_alu_dat, o_err <= 0.
//   If head ctrl is 5..7: o_dat <= 8'h00, o_err <= 1. The illegal result still consumes a seq tag.
//  If o_vld & i_rdy & ~pop: o_vld <= 0; o_dat, o_err and o_seq hold their last values.
//  If o_vld & ~i_rdy: o_dat, o_err and o_seq remain stable until accepted.
//  Push and pop in the same cycle: count unchanged, both pointers advance; pointers wrap modulo DEPTH.
//  Latency: a request accepted at edge k into an empty FIFO, with the output slot free or draining,
//   appears at o_vld/o_dat after edge k+1. Sustained throughput is 1 result per clock.
//  Ordering: results emerge strictly in request order.
//  Result widths: add and sub are mod 16, with o_dat[7:4] = 0. mult is the full 8-bit product.
//   nand and nor are bitwise 4-bit, with o_dat[7:4] = 0.
// TESTING
//  1. Reset, then push ctrl=2 op1=F op2=F -> one cycle later o_vld=1, o_dat=8'hE1, o_err=0, o_seq=0.
//  2. i_rdy=1; back-to-back push add 9+8, sub 3-5, nand A,C, nor A,C -> 8'h01, 8'h0E, 8'h07, 8'h01
//     on consecutive cycles, seq 0,1,2,3.
//  3. i_rdy=0; push continuously with DEPTH=4 -> 5 requests accepted, then o_rdy=0, o_count=4, o_dat stable.
//     Raise i_rdy -> 5 results in order, o_rdy re-asserts after the first pop.
//  4. Push ctrl=3'b110 op1=7 op2=2 -> o_vld=1, o_dat=8'h00, o_err=1, seq advances.
//     The next legal op has o_err=0.
//  5. Assert i_rst mid-stream with 3 queued and o_vld=1 -> o_vld=0, o_count=0 with no clock edge.
//     After release, the first result has o_seq=0.
//  6. Push 17 ops with i_rdy=1 -> o_seq runs 0..15, then 0. Random ops checked against an add/sub/mult/nand/nor model.

Source files
------------

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: request FIFO in front of alu_gate plus a registered,
// back-pressurable result slot carrying an error flag and a sequence tag.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_vld,
  output logic          o_rdy,
  input  logic [2:0]    i_ctrl,
  input  logic [3:0]    i_op1,
  input  logic [3:0]    i_op2,
  output logic [2:0]    o_alu_ctrl,
  output logic [3:0]    o_alu_op1,
  output logic [3:0]    o_alu_op2,
  input  logic [7:0]    i_alu_dat,
  output logic          o_vld,
  input  logic          i_rdy,
  output logic [7:0]    o_dat,
  output logic          o_err,
  output logic [3:0]    o_seq,
  output logic [AW:0]   o_count
);

  typedef struct packed {
    logic [2:0] ctrl;
    logic [3:0] op1;
    logic [3:0] op2;
  } req_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  req_t          mem_q [DEPTH];
  req_t          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    seq_cnt_q, seq_cnt_d;
  logic          vld_q, vld_d;
  logic [7:0]    dat_q, dat_d;
  logic          err_q, err_d;
  logic [3:0]    oseq_q, oseq_d;

  logic          push, pop, empty;
  req_t          head;

  // Ready is purely occupancy based: a full FIFO refuses even while popping.
  assign empty   = (count_q == '0);
  assign o_rdy   = (count_q != FULL);
  assign push    = i_vld & o_rdy;
  assign pop     = ~empty & (~vld_q | i_rdy);
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  assign o_alu_ctrl = head.ctrl;
  assign o_alu_op1  = head.op1;
  assign o_alu_op2  = head.op2;
  assign o_vld      = vld_q;
  assign o_dat      = dat_q;
  assign o_err      = err_q;
  assign o_seq      = oseq_q;
  assign o_count    = count_q;

  // Next state: FIFO write/read, occupancy, and result slot load/drain.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    seq_cnt_d = seq_cnt_q;
    vld_d     = vld_q;
    dat_d     = dat_q;
    err_d     = err_q;
    oseq_d    = oseq_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{ctrl: i_ctrl, op1: i_op1, op2: i_op2};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      vld_d     = 1'b1;
      oseq_d    = seq_cnt_q;
      seq_cnt_d = seq_cnt_q + 4'd1;
      // Illegal opcodes still produce a result (zero data) and burn a tag.
      if (head.ctrl <= 3'd4) begin
        dat_d = i_alu_dat;
        err_d = 1'b0;
      end else begin
        dat_d = 8'h00;
        err_d = 1'b1;
      end
    end else if (vld_q & i_rdy) begin
      vld_d = 1'b0;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with immediate reset; queued entries are discarded.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      seq_cnt_q <= '0;
      vld_q     <= 1'b0;
      dat_q     <= 8'h00;
      err_q     <= 1'b0;
      oseq_q    <= 4'h0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      seq_cnt_q <= seq_cnt_d;
      vld_q     <= vld_d;
      dat_q     <= dat_d;
      err_q     <= err_d;
      oseq_q    <= oseq_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed + random stimulus against a queue-based
// reference of the issue stage and an arithmetic model of the ALU.
module tb_alu_issue_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic i_clk = 0, i_rst = 0, i_vld = 0, i_rdy = 0;
  logic [2:0] i_ctrl = 0;
  logic [3:0] i_op1 = 0, i_op2 = 0;
  logic o_rdy, o_vld, o_err;
  logic [2:0] o_alu_ctrl;
  logic [3:0] o_alu_op1, o_alu_op2, o_seq;
  logic [7:0] i_alu_dat, o_dat;
  logic [AW:0] o_count;

  alu_issue_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_vld(i_vld), .o_rdy(o_rdy),
    .i_ctrl(i_ctrl), .i_op1(i_op1), .i_op2(i_op2),
    .o_alu_ctrl(o_alu_ctrl), .o_alu_op1(o_alu_op1), .o_alu_op2(o_alu_op2),
    .i_alu_dat(i_alu_dat), .o_vld(o_vld), .i_rdy(i_rdy), .o_dat(o_dat),
    .o_err(o_err), .o_seq(o_seq), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {int ctrl; int a; int b;} req_t;

  // Arithmetic result of an opcode as seen at the ALU output.
  function automatic int alu_fn(int c, int a, int b);
    case (c)
      0: return (a + b) % 16;
      1: return (a - b + 16) % 16;
      2: return a * b;
      3: return 15 - (a & b);
      4: return 15 - (a | b);
      default: return 255;  // garbage the DUT must replace with zero
    endcase
  endfunction

  // Stand-in for alu_gate, combinational in the head fields.
  always_comb i_alu_dat = 8'(alu_fn(int'(o_alu_ctrl), int'(o_alu_op1), int'(o_alu_op2)));

  int n_cmp = 0, n_err = 0;
  req_t fifo[$];
  int m_v, m_dat, m_err, m_seq, seqc;
  int n_out;
  int seq_log[$];

  task automatic chk(string tag, int obs, int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    fifo.delete();
    m_v = 0; m_dat = 0; m_err = 0; m_seq = 0; seqc = 0;
  endtask

  task automatic chk_outs();
    chk("vld", int'(o_vld), m_v);
    chk("dat", int'(o_dat), m_dat);
    chk("err", int'(o_err), m_err);
    chk("seq", int'(o_seq), m_seq);
    chk("count", int'(o_count), fifo.size());
    chk("rdy", int'(o_rdy), int'(fifo.size() != DEPTH));
  endtask

  // One clock: predict from current inputs, advance, then compare.
  task automatic step();
    bit push, pop;
    req_t r, h;
    r = '{int'(i_ctrl), int'(i_op1), int'(i_op2)};
    push = i_vld && (fifo.size() != DEPTH);
    pop  = (fifo.size() != 0) && (!m_v || i_rdy);
    if (fifo.size() != 0) begin
      chk("head_ctrl", int'(o_alu_ctrl), fifo[0].ctrl);
      chk("head_op1", int'(o_alu_op1), fifo[0].a);
      chk("head_op2", int'(o_alu_op2), fifo[0].b);
    end else begin
      chk("idle_alu", int'({o_alu_ctrl, o_alu_op1, o_alu_op2}), 0);
    end
    if (o_vld && i_rdy) begin
      n_out++;
      seq_log.push_back(int'(o_seq));
    end
    @(posedge i_clk); #1;
    if (pop) begin
      h = fifo.pop_front();
      m_v = 1;
      m_err = (h.ctrl > 4) ? 1 : 0;
      m_dat = m_err ? 0 : alu_fn(h.ctrl, h.a, h.b);
      m_seq = seqc;
      seqc = (seqc + 1) % 16;
    end else if (m_v && i_rdy) begin
      m_v = 0;
    end
    if (push) fifo.push_back(r);
    chk_outs();
  endtask

  task automatic do_reset();
    i_rst = 1; #1;
    model_clear();
    chk_outs();
    @(posedge i_clk); #1;
    i_rst = 0;
    chk_outs();
  endtask

  task automatic drive(int c, int a, int b);
    i_vld = 1; i_ctrl = 3'(c); i_op1 = 4'(a); i_op2 = 4'(b);
  endtask

  int acc, d0;
  int e2[4] = '{1, 14, 7, 1};

  initial begin
    // T1: reset state and first-result latency
    do_reset();
    i_rdy = 1;
    drive(2, 15, 15); step();
    i_vld = 0;
    chk("t1_lat_vld", int'(o_vld), 0);
    step();
    chk("t1_dat", int'(o_dat), 8'hE1);
    chk("t1_vld", int'(o_vld), 1);
    chk("t1_seq", int'(o_seq), 0);
    step();

    // T2: back-to-back ops, one result per clock
    do_reset();
    i_rdy = 1;
    drive(0, 9, 8);   step();
    drive(1, 3, 5);   step(); chk("t2_r0", int'(o_dat), e2[0]); chk("t2_s0", int'(o_seq), 0);
    drive(3, 10, 12); step(); chk("t2_r1", int'(o_dat), e2[1]); chk("t2_s1", int'(o_seq), 1);
    drive(4, 10, 12); step(); chk("t2_r2", int'(o_dat), e2[2]); chk("t2_s2", int'(o_seq), 2);
    i_vld = 0;        step(); chk("t2_r3", int'(o_dat), e2[3]); chk("t2_s3", int'(o_seq), 3);
    step();

    // T3: fill under back-pressure, then drain in order
    do_reset();
    i_rdy = 0; acc = 0;
    for (int i = 0; i < 7; i++) begin
      drive($urandom_range(0, 4), $urandom_range(0, 15), $urandom_range(0, 15));
      if (o_rdy) acc++;
      step();
      if (i == 1) d0 = int'(o_dat);
    end
    chk("t3_acc", acc, 5);
    chk("t3_rdy", int'(o_rdy), 0);
    chk("t3_count", int'(o_count), 4);
    chk("t3_stable", int'(o_dat), d0);
    i_vld = 0; i_rdy = 1; n_out = 0;
    step();
    chk("t3_rdy_back", int'(o_rdy), 1);
    for (int i = 0; i < 6; i++) step();
    chk("t3_drained", n_out, 5);

    // T4: illegal opcode, then a legal one
    drive(6, 7, 2); step();
    drive(0, 1, 2); step();
    chk("t4_err", int'(o_err), 1);
    chk("t4_dat", int'(o_dat), 0);
    i_vld = 0; step();
    chk("t4_legal_err", int'(o_err), 0);
    chk("t4_legal_dat", int'(o_dat), 3);
    step();

    // T5: async reset with 3 queued and a pending result
    i_rdy = 0;
    for (int i = 0; i < 4; i++) begin drive(0, i, 1); step(); end
    i_vld = 0;
    chk("t5_pre_vld", int'(o_vld), 1);
    chk("t5_pre_cnt", int'(o_count), 3);
    i_rst = 1; #1;
    chk("t5_async_vld", int'(o_vld), 0);
    chk("t5_async_cnt", int'(o_count), 0);
    chk("t5_async_rdy", int'(o_rdy), 1);
    model_clear();
    @(posedge i_clk); #1;
    i_rst = 0;
    i_rdy = 1;
    drive(1, 5, 9); step();
    i_vld = 0; step();
    chk("t5_seq0", int'(o_seq), 0);
    chk("t5_dat", int'(o_dat), 12);
    step();

    // T6: 17 random ops, tag wrap
    do_reset();
    i_rdy = 1;
    seq_log.delete();
    for (int i = 0; i < 17; i++) begin
      drive($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
      step();
    end
    i_vld = 0;
    for (int i = 0; i < 3; i++) step();
    chk("t6_nres", seq_log.size(), 17);
    for (int i = 0; i < seq_log.size(); i++) chk("t6_seq", seq_log[i], i % 16);

    // Random valid/ready traffic against the model
    for (int i = 0; i < 300; i++) begin
      i_vld = 1'($urandom_range(0, 1));
      i_ctrl = 3'($urandom_range(0, 7));
      i_op1 = 4'($urandom); i_op2 = 4'($urandom);
      i_rdy = 1'($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
